// File: rtl/single_ram_arbiter.sv
// single_ram_arbiter
// Two-requester arbiter and sequencer in front of one single-port RAM.
// Ports A and B issue read/write requests over valid/ready. Grants alternate
// round-robin under contention. Each grant is run as a fixed strobe sequence:
//   write: IDLE -> WR -> IDLE
//   read : IDLE -> RA -> RD -> IDLE, then a one-cycle rsp_valid to the owner.
// The RAM strobes depend only on registered state and the latched request, so
// no combinational path runs from the requester inputs to the RAM pins.
// Optional build macro SINGLE_RAM_ARB_FIXED_PRIO_EN: port A always wins
// contention and no grant history is kept.
module single_ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wdata_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RA   = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  grant_b;
  logic                  accept;
  logic                  req_we;
  logic                  prefer_a;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  owner_b_p0;

`ifdef SINGLE_RAM_ARB_FIXED_PRIO_EN
  assign prefer_a = 1'b1;
`else
  logic last_grant_b;

  assign prefer_a = last_grant_b;

  // Grant history: the port that did not win last time wins the next contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_b <= 1'b1;
    end else if (accept) begin
      last_grant_b <= grant_b;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Selection, ready and next state; ready is offered only while idle.
  always_comb begin
    state_d = state_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    grant_b = 1'b0;
    accept  = 1'b0;
    req_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_valid && (!b_valid || prefer_a)) begin
          a_ready = 1'b1;
        end else if (b_valid) begin
          b_ready = 1'b1;
          grant_b = 1'b1;
        end
        accept = a_ready | b_ready;
        req_we = grant_b ? b_we : a_we;
        if (accept) begin
          state_d = req_we ? WR : RA;
        end
      end
      WR:      state_d = IDLE;
      RA:      state_d = RD;
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch: address, write data and owner of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0    <= '0;
      wdata_p0   <= '0;
      owner_b_p0 <= 1'b0;
    end else if (accept) begin
      addr_p0    <= grant_b ? b_addr : a_addr;
      wdata_p0   <= grant_b ? b_wdata : a_wdata;
      owner_b_p0 <= grant_b;
    end
  end

  // RAM strobes decoded from the registered state only.
  always_comb begin
    ram_cs       = (state_q != IDLE);
    ram_we       = (state_q == WR);
    ram_oe       = (state_q == RD);
    ram_wdata_oe = (state_q == WR);
    ram_addr     = addr_p0;
    ram_wdata    = wdata_p0;
  end

  // Read return: capture the bus at the end of RD and pulse the owner's valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_rsp_valid <= (state_q == RD) && !owner_b_p0;
      b_rsp_valid <= (state_q == RD) && owner_b_p0;
      if ((state_q == RD) && !owner_b_p0) begin
        a_rdata <= ram_rdata;
      end
      if ((state_q == RD) && owner_b_p0) begin
        b_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_single_ram_arbiter.sv
// tb_single_ram_arbiter
// Bench for single_ram_arbiter with a behavioural single-port RAM and a
// transaction-level reference model: each accepted request is recorded with its
// accept cycle, and the expected strobes, ready, responses and read data of any
// cycle follow from that record and the arbitration rule.
module tb_single_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_cs, ram_we, ram_oe, ram_wdata_oe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  single_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM: write on cs&we, registered read on cs&!we.
  logic [DW-1:0] ram_mem [16] = '{1: 32'h11, 2: 32'h22, default: 32'h0};
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_q <= ram_mem[ram_addr];
    end
  end
  assign ram_rdata = ram_oe ? ram_q : '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state.
  int            m_start = 0, m_end = 0, m_kind = 0;  // kind 1 = write, 2 = read
  bit            m_last = 1'b1;                        // 1 = B granted last
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_rsp_a = -1, m_rsp_b = -1;
  logic [DW-1:0] m_rsp_a_dat = '0, m_rsp_b_dat = '0, m_rda = '0, m_rdb = '0;
  logic [DW-1:0] m_mem [16] = '{1: 32'h11, 2: 32'h22, default: 32'h0};
  bit            took_a = 1'b0, took_b = 1'b0;
  int            last_acc = 0;
  int            dut_a_rsp_cyc = -1, dut_a_rsp_cnt = 0, dut_b_rsp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare the DUT against the model for the current cycle, then advance the model.
  task automatic model_cmp();
    bit idle, e_ra, e_rb, e_cs, e_we, e_oe, w;
    int off;
    if (!rst_n) begin
      m_end = 0; m_kind = 0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
      m_rsp_a = -1; m_rsp_b = -1; m_rda = '0; m_rdb = '0;
      took_a = 1'b0; took_b = 1'b0;
      chk("rst_cs", 64'(ram_cs), 64'(0));
      chk("rst_we", 64'(ram_we), 64'(0));
      chk("rst_oe", 64'(ram_oe), 64'(0));
      chk("rst_wdata_oe", 64'(ram_wdata_oe), 64'(0));
      chk("rst_addr", 64'(ram_addr), 64'(0));
      chk("rst_wdata", 64'(ram_wdata), 64'(0));
      chk("rst_a_rsp", 64'(a_rsp_valid), 64'(0));
      chk("rst_b_rsp", 64'(b_rsp_valid), 64'(0));
      chk("rst_a_rdata", 64'(a_rdata), 64'(0));
      chk("rst_b_rdata", 64'(b_rdata), 64'(0));
      return;
    end
    idle = (cyc >= m_end);
    off  = cyc - m_start;
    e_ra = 1'b0;
    e_rb = 1'b0;
    if (idle) begin
`ifdef SINGLE_RAM_ARB_FIXED_PRIO_EN
      if (a_valid) e_ra = 1'b1;
      else if (b_valid) e_rb = 1'b1;
`else
      if (a_valid && b_valid) begin
        if (m_last) e_ra = 1'b1;
        else        e_rb = 1'b1;
      end else if (a_valid) e_ra = 1'b1;
      else if (b_valid) e_rb = 1'b1;
`endif
    end
    e_cs = !idle;
    e_we = !idle && (m_kind == 1);
    e_oe = !idle && (m_kind == 2) && (off == 2);
    if (cyc == m_rsp_a) m_rda = m_rsp_a_dat;
    if (cyc == m_rsp_b) m_rdb = m_rsp_b_dat;
    chk("a_ready", 64'(a_ready), 64'(e_ra));
    chk("b_ready", 64'(b_ready), 64'(e_rb));
    chk("ram_cs", 64'(ram_cs), 64'(e_cs));
    chk("ram_we", 64'(ram_we), 64'(e_we));
    chk("ram_oe", 64'(ram_oe), 64'(e_oe));
    chk("ram_wdata_oe", 64'(ram_wdata_oe), 64'(e_we));
    chk("bus_safe", 64'(ram_oe & ram_wdata_oe), 64'(0));
    chk("ram_addr", 64'(ram_addr), 64'(m_addr));
    chk("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
    chk("a_rsp_valid", 64'(a_rsp_valid), 64'(cyc == m_rsp_a));
    chk("b_rsp_valid", 64'(b_rsp_valid), 64'(cyc == m_rsp_b));
    chk("a_rdata", 64'(a_rdata), 64'(m_rda));
    chk("b_rdata", 64'(b_rdata), 64'(m_rdb));
    if (a_rsp_valid) begin dut_a_rsp_cyc = cyc; dut_a_rsp_cnt++; end
    if (b_rsp_valid) dut_b_rsp_cnt++;
    took_a = e_ra;
    took_b = e_rb;
    if (e_ra || e_rb) begin
      w        = e_rb ? b_we : a_we;
      m_start  = cyc;
      m_kind   = w ? 1 : 2;
      m_end    = cyc + (w ? 2 : 3);
      m_addr   = e_rb ? b_addr : a_addr;
      m_wdata  = e_rb ? b_wdata : a_wdata;
      m_last   = e_rb;
      last_acc = cyc;
      if (w) m_mem[m_addr] = m_wdata;
      else if (e_rb) begin m_rsp_b = cyc + 3; m_rsp_b_dat = m_mem[m_addr]; end
      else begin m_rsp_a = cyc + 3; m_rsp_a_dat = m_mem[m_addr]; end
    end
  endtask

  // One clock cycle: check at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic req(input bit pb, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bit got = 1'b0;
    if (pb) begin b_valid = 1'b1; b_we = we; b_addr = ad; b_wdata = wd; end
    else    begin a_valid = 1'b1; a_we = we; a_addr = ad; a_wdata = wd; end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = pb ? took_b : took_a;
    end
    if (pb) b_valid = 1'b0;
    else    a_valid = 1'b0;
    chk("req_accept", 64'(got), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, snap, start, ntx, guard, na, nb, first, code;
    int gq[$];
    bit both, got_a, got_b;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Write then read A addr 3.
    req(1'b0, 1'b1, 4'd3, 32'hDEADBEEF);
    step();
    req(1'b0, 1'b0, 4'd3, 32'h0);
    acc = last_acc;
    repeat (4) step();
    chk("t1_latency", 64'(dut_a_rsp_cyc - acc), 64'(3));
    chk("t1_a_rdata", 64'(a_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("t1_b_rsp_none", 64'(dut_b_rsp_cnt), 64'(0));

    // Reset, then both ports hold reads continuously.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    both = 1'b0;
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      step();
      if (took_a && took_b) both = 1'b1;
      if (took_a) gq.push_back(0);
      if (took_b) gq.push_back(1);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) step();
    code = (gq.size() >= 4) ? (gq[0] * 8 + gq[1] * 4 + gq[2] * 2 + gq[3]) : -1;
    chk("t2_two_ready", 64'(both), 64'(0));
`ifndef SINGLE_RAM_ARB_FIXED_PRIO_EN
    chk("t2_order_abab", 64'(code), 64'(5));
    chk("t2_b_rdata", 64'(b_rdata), 64'h22);
`endif
    chk("t2_a_rdata", 64'(a_rdata), 64'h11);

    // B write vs A read of the same address, after A was granted last.
    req(1'b0, 1'b0, 4'd1, 32'h0);
    repeat (3) step();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd5; a_wdata = 32'hFFFF_FFFF;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 32'h5;
    first = -1; got_a = 1'b0; got_b = 1'b0;
    for (int i = 0; i < 20 && !(got_a && got_b); i++) begin
      step();
      if (took_a) begin got_a = 1'b1; a_valid = 1'b0; if (first < 0) first = 0; end
      if (took_b) begin got_b = 1'b1; b_valid = 1'b0; if (first < 0) first = 1; end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) step();
`ifndef SINGLE_RAM_ARB_FIXED_PRIO_EN
    chk("t3_b_first", 64'(first), 64'(1));
    chk("t3_a_reads_5", 64'(a_rdata), 64'h5);
`endif

    // Reset during RA of an A read.
    snap = dut_a_rsp_cnt;
    req(1'b0, 1'b0, 4'd7, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t4_cs_async", 64'(ram_cs), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t4_no_rsp", 64'(dut_a_rsp_cnt - snap), 64'(0));
    start = cyc;
    req(1'b0, 1'b1, 4'd7, 32'h77);
    chk("t4_accept_first", 64'(last_acc - start), 64'(0));
    repeat (2) step();

    // Random run of 1000 transactions.
    ntx = 0;
    guard = 0;
    took_a = 1'b0;
    took_b = 1'b0;
    while (ntx < 1000 && guard < 20000) begin
      if (took_a) begin ntx++; a_valid = 1'b0; end
      if (took_b) begin ntx++; b_valid = 1'b0; end
      if (!a_valid) begin
        a_we = 1'($urandom_range(1, 0)); a_addr = 4'($urandom_range(15, 0)); a_wdata = $urandom;
        a_valid = 1'($urandom_range(1, 0));
      end else if ($urandom_range(15, 0) == 0) a_valid = 1'b0;
      if (!b_valid) begin
        b_we = 1'($urandom_range(1, 0)); b_addr = 4'($urandom_range(15, 0)); b_wdata = $urandom;
        b_valid = 1'($urandom_range(1, 0));
      end else if ($urandom_range(15, 0) == 0) b_valid = 1'b0;
      step();
      guard++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (4) step();
    chk("rand_done", 64'(ntx >= 1000), 64'(1));

`ifdef SINGLE_RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: A starves B while it stays valid.
    na = 0; nb = 0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    for (int i = 0; i < 30; i++) begin
      step();
      if (took_a) na++;
      if (took_b) nb++;
    end
    chk("fp_b_never", 64'(nb), 64'(0));
    chk("fp_a_many", 64'(na >= 5), 64'(1));
    a_valid = 1'b0;
    got_b = 1'b0;
    for (int i = 0; i < 10 && !got_b; i++) begin
      step();
      got_b = took_b;
    end
    b_valid = 1'b0;
    chk("fp_b_after_a", 64'(got_b), 64'(1));
    repeat (4) step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/single_ram_arbiter.md
Name: single_ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port RAM (`addr` / `data` inout / `cs` / `we` / `oe` interface).
- Accepts read/write requests from ports A and B over valid/ready handshakes and grants them round-robin.
- Drives the RAM strobes with correct cycle timing and returns read data to the owning requester.
- Sits between two bus masters (e.g. DMA and CPU side) and one RAM instance. The top level joins `ram_wdata`/`ram_wdata_oe` and `ram_rdata` onto the RAM's inout `data` bus.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 32, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_rsp_valid  out  1  port A read data valid (1-cycle pulse).
- a_rdata  out  DATA_WIDTH  port A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rdata: same as port A, for port B.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  data to the RAM data bus.
- ram_wdata_oe  out  1  tri-state enable for ram_wdata onto the inout bus.
- ram_rdata  in  DATA_WIDTH  RAM data bus as seen by the controller.

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous, active-low (`rst_n`).
- Reset values:
  - State = IDLE; all ram_* strobes = 0.
  - ram_addr = 0; ram_wdata = 0.
  - a/b_rsp_valid = 0; a/b_rdata = 0.
  - last_grant = B, so A wins the first contention.
- States: IDLE, WR, RA (read address), RD (read data). ram_* outputs are decoded from registered state/latches only (Moore); no combinational path from a_*/b_* to ram_*.
- IDLE:
  - ready is combinational and asserted only in IDLE, only to the selected requester.
  - Selection:
    - only one valid → that port;
    - both valid → the port opposite last_grant.
  - On an accept edge:
    - latch addr, wdata, we and owner id;
    - update last_grant;
    - go to WR if we = 1, else RA.
  - No valid → stay in IDLE.
- WR (1 cycle):
  - ram_cs = 1, ram_we = 1, ram_oe = 0, ram_wdata_oe = 1.
  - The RAM writes at the end of the cycle. Next state IDLE.
  - No response pulse for writes.
- RA (1 cycle):
  - ram_cs = 1, ram_we = 0, ram_oe = 0; the RAM registers the read at the end of the cycle.
  - Next state RD.
- RD (1 cycle):
  - ram_cs = 1, ram_we = 0, ram_oe = 1; address held.
  - At the end of the cycle, capture ram_rdata into the owner's rdata and set the owner's rsp_valid for exactly one cycle. Next state IDLE.
- Throughput and latency:
  - Write: one per 2 cycles.
  - Read: one per 3 cycles. rsp_valid is high in the 3rd cycle after the accept edge.
  - rdata holds its value until the next read response to the same port.
- Bus safety: ram_wdata_oe = 1 only in WR; ram_oe = 1 only in RD. The two are never both high.
- Arbitration:
  - A requester that deasserts valid before ready has no effect.
  - A request held valid while the other port is served is granted at the next IDLE if contention exists (no starvation: worst-case wait is 1 transaction).
  - Inputs of a non-accepted requester are ignored.
- Reset mid-transaction: the transaction is aborted, outputs return to reset values immediately, and no rsp_valid is issued. A write in progress may or may not have committed.

Optional Feature:
- Macro: SINGLE_RAM_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, A always wins contention; last_grant is not implemented. B is served only when A is not valid in IDLE.
- When undefined: round-robin as specified above.

Test Plan:
- Write A addr 3 = 0xDEADBEEF, then read A addr 3 → a_ready pulses once per request; the RD cycle has ram_oe = 1; a_rsp_valid high 3 cycles after the read accept; a_rdata = 0xDEADBEEF; b_rsp_valid stays 0.
- A and B both valid reads (A addr 1, B addr 2, preloaded 0x11 / 0x22) held continuously → grants alternate A, B, A, B; each rsp_valid goes to its own port with the correct data; never two ready pulses in one cycle.
- B write addr 5 = 0x5 while A holds a read of addr 5 → B granted first when last_grant = A, then A reads 0x5 (write-before-read ordering).
- Every cycle over a random 1000-transaction run → ram_wdata_oe & ram_oe never both 1; ram_cs = 0 in every IDLE cycle.
- Assert rst_n = 0 during the RA state of an A read → ram_cs drops asynchronously; no a_rsp_valid; after release the first request is accepted normally from IDLE.
- With SINGLE_RAM_ARB_FIXED_PRIO_EN, A and B continuously valid → only A is granted; B is granted only after A deasserts valid.
